// File: rtl/use_lane_sequencer.sv
// Sequences readout lane-mask changes: pause readout, drain, apply the mask,
// then hold the pause through a settle window before releasing.
module use_lane_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned DRAIN_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dcs_lane_wr,
  input  logic [3:0] dcs_lane_data,
  input  logic       serial_lane_wr,
  input  logic [3:0] serial_lane_data,
  input  logic       readout_idle,
  input  logic       clear_err,
  output logic [3:0] use_lane,
  output logic [1:0] lane_src,
  output logic       readout_pause,
  output logic       busy,
  output logic       update_done,
  output logic       drain_timeout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAIN  = 2'd1,
    S_APPLY  = 2'd2,
    S_SETTLE = 2'd3
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] DRAIN_LAST  = 16'(DRAIN_TIMEOUT - 1);

  state_t      state, next_state;
  logic [3:0]  dcs_reg, serial_reg, target;
  logic [1:0]  tsrc;
  logic [15:0] cnt;
  logic        drain_expired;
  logic        pause_d, busy_d, done_d;

  // DCS wins when non-zero, then SERIAL, else no lanes.
  always_comb begin
    target = 4'd0;
    tsrc   = 2'd0;
    if (dcs_reg != 4'd0) begin
      target = dcs_reg;
      tsrc   = 2'd2;
    end else if (serial_reg != 4'd0) begin
      target = serial_reg;
      tsrc   = 2'd1;
    end
  end

  assign drain_expired = (state == S_DRAIN) && !readout_idle && (cnt == DRAIN_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (target != use_lane || tsrc != lane_src) next_state = S_DRAIN;
      S_DRAIN:  if (readout_idle || cnt == DRAIN_LAST) next_state = S_APPLY;
      S_APPLY:  next_state = S_SETTLE;
      S_SETTLE: if (cnt == SETTLE_LAST) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state register.
  always_comb begin
    pause_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    if (next_state != S_IDLE) begin
      pause_d = 1'b1;
      busy_d  = 1'b1;
    end
    if (state == S_SETTLE && next_state == S_IDLE) done_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dcs_reg       <= 4'd0;
      serial_reg    <= 4'd0;
      use_lane      <= 4'd0;
      lane_src      <= 2'd0;
      readout_pause <= 1'b0;
      busy          <= 1'b0;
      update_done   <= 1'b0;
      drain_timeout <= 1'b0;
      cnt           <= 16'd0;
    end else begin
      if (dcs_lane_wr)    dcs_reg    <= dcs_lane_data;
      if (serial_lane_wr) serial_reg <= serial_lane_data;
      readout_pause <= pause_d;
      busy          <= busy_d;
      update_done   <= done_d;
      if (drain_expired)  drain_timeout <= 1'b1;
      else if (clear_err) drain_timeout <= 1'b0;
      case (state)
        S_IDLE:   cnt <= 16'd0;
        S_DRAIN:  if (next_state == S_DRAIN) cnt <= cnt + 16'd1;
        S_APPLY: begin
          // Sampled here so strobes that landed during DRAIN are honoured.
          use_lane <= target;
          lane_src <= tsrc;
          cnt      <= 16'd0;
        end
        S_SETTLE: if (cnt != SETTLE_LAST) cnt <= cnt + 16'd1;
        default:  cnt <= 16'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_use_lane_sequencer.sv
// Directed bench for use_lane_sequencer: table of lane writes plus hand-timed
// sequences for drain timeout, mid-drain absorption, settle re-request and reset.
module tb_use_lane_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dcs_lane_wr = 1'b0;
  logic [3:0] dcs_lane_data = 4'd0;
  logic       serial_lane_wr = 1'b0;
  logic [3:0] serial_lane_data = 4'd0;
  logic       readout_idle = 1'b1;
  logic       clear_err = 1'b0;
  logic [3:0] use_lane;
  logic [1:0] lane_src;
  logic       readout_pause, busy, update_done, drain_timeout;

  int n_vec = 0;
  int n_err = 0;

  use_lane_sequencer #(.SETTLE_CYCLES(16), .DRAIN_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .dcs_lane_wr(dcs_lane_wr), .dcs_lane_data(dcs_lane_data),
    .serial_lane_wr(serial_lane_wr), .serial_lane_data(serial_lane_data),
    .readout_idle(readout_idle), .clear_err(clear_err),
    .use_lane(use_lane), .lane_src(lane_src), .readout_pause(readout_pause),
    .busy(busy), .update_done(update_done), .drain_timeout(drain_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dwr;
    logic [3:0] dd;
    logic       swr;
    logic [3:0] sd;
    logic       seq;
    logic [3:0] exp_lane;
    logic [1:0] exp_src;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called in cycle 0; returns in cycle 1.
  task automatic strobe(input logic dwr, input logic [3:0] dd, input logic swr, input logic [3:0] sd);
    dcs_lane_wr = dwr; dcs_lane_data = dd;
    serial_lane_wr = swr; serial_lane_data = sd;
    tick();
    dcs_lane_wr = 1'b0; serial_lane_wr = 1'b0;
  endtask

  // Returns in the cycle where update_done is high.
  task automatic wait_done(input string name, input int bound);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      if (update_done) seen = 1'b1;
    end
    check(name, 16'(seen), 16'd1);
  endtask

  initial begin
    logic saw_busy;
    logic pause_ok;

    vecs[0] = '{1'b0, 4'h0, 1'b1, 4'h3, 1'b0, 4'h5, 2'd2};
    vecs[1] = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 4'h3, 2'd1};
    vecs[2] = '{1'b1, 4'hC, 1'b0, 4'h0, 1'b1, 4'hC, 2'd2};
    vecs[3] = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 4'h3, 2'd1};
    vecs[4] = '{1'b1, 4'h0, 1'b1, 4'h9, 1'b1, 4'h9, 2'd1};
    vecs[5] = '{1'b0, 4'h0, 1'b1, 4'h9, 1'b0, 4'h9, 2'd1};
    vecs[6] = '{1'b1, 4'h9, 1'b0, 4'h0, 1'b1, 4'h9, 2'd2};
    vecs[7] = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 4'h9, 2'd1};

    // Clock / reset
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_use_lane", 16'(use_lane), 16'h0);
    check("rst_lane_src", 16'(lane_src), 16'h0);
    check("rst_pause", 16'(readout_pause), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_done", 16'(update_done), 16'h0);
    check("rst_timeout", 16'(drain_timeout), 16'h0);

    // First update, cycle-exact
    strobe(1'b1, 4'h5, 1'b0, 4'h0);
    check("c1_busy", 16'(busy), 16'h0);
    check("c1_pause", 16'(readout_pause), 16'h0);
    tick();
    check("c2_pause", 16'(readout_pause), 16'h1);
    check("c2_busy", 16'(busy), 16'h1);
    tick();
    check("c3_use_lane", 16'(use_lane), 16'h0);
    tick();
    check("c4_use_lane", 16'(use_lane), 16'h5);
    check("c4_lane_src", 16'(lane_src), 16'h2);
    pause_ok = 1'b1;
    for (int c = 4; c < 20; c++) begin
      if (c > 4) tick();
      if (!readout_pause || update_done) pause_ok = 1'b0;
    end
    check("settle_pause_held", 16'(pause_ok), 16'h1);
    tick();
    check("c20_done", 16'(update_done), 16'h1);
    check("c20_pause", 16'(readout_pause), 16'h0);
    check("c20_busy", 16'(busy), 16'h0);
    tick();
    check("c21_done", 16'(update_done), 16'h0);

    // Table-driven arbitration vectors
    for (int v = 0; v < 8; v++) begin
      strobe(vecs[v].dwr, vecs[v].dd, vecs[v].swr, vecs[v].sd);
      if (vecs[v].seq) begin
        tick();
        check($sformatf("v%0d_busy", v), 16'(busy), 16'h1);
        wait_done($sformatf("v%0d_done", v), 60);
      end else begin
        saw_busy = 1'b0;
        for (int c = 0; c < 6; c++) begin
          tick();
          if (busy) saw_busy = 1'b1;
        end
        check($sformatf("v%0d_no_seq", v), 16'(saw_busy), 16'h0);
      end
      check($sformatf("v%0d_use_lane", v), 16'(use_lane), 16'(vecs[v].exp_lane));
      check($sformatf("v%0d_lane_src", v), 16'(lane_src), 16'(vecs[v].exp_src));
      tick();
    end

    // Drain timeout: 8 cycles in DRAIN (cycles 2..9), forced apply
    readout_idle = 1'b0;
    strobe(1'b1, 4'h6, 1'b0, 4'h0);
    for (int c = 1; c < 9; c++) tick();
    check("to_c9_pause", 16'(readout_pause), 16'h1);
    check("to_c9_timeout", 16'(drain_timeout), 16'h0);
    check("to_c9_use_lane", 16'(use_lane), 16'h9);
    tick();
    check("to_c10_timeout", 16'(drain_timeout), 16'h1);
    check("to_c10_use_lane", 16'(use_lane), 16'h9);
    tick();
    check("to_c11_use_lane", 16'(use_lane), 16'h6);
    check("to_c11_lane_src", 16'(lane_src), 16'h2);
    readout_idle = 1'b1;
    wait_done("to_done", 40);
    check("to_sticky", 16'(drain_timeout), 16'h1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("to_cleared", 16'(drain_timeout), 16'h0);

    // clear_err coinciding with a fresh timeout: set wins
    readout_idle = 1'b0;
    strobe(1'b1, 4'h7, 1'b0, 4'h0);
    for (int c = 1; c < 8; c++) tick();
    clear_err = 1'b1;
    tick();
    tick();
    clear_err = 1'b0;
    check("to_set_wins", 16'(drain_timeout), 16'h1);
    readout_idle = 1'b1;
    wait_done("to2_done", 40);
    check("to2_use_lane", 16'(use_lane), 16'h7);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("to2_cleared", 16'(drain_timeout), 16'h0);

    // Write during DRAIN is absorbed; write during SETTLE starts a second sequence
    readout_idle = 1'b0;
    strobe(1'b1, 4'h1, 1'b0, 4'h0);
    tick();
    check("ab_c2_busy", 16'(busy), 16'h1);
    dcs_lane_wr = 1'b1; dcs_lane_data = 4'h2;
    tick();
    dcs_lane_wr = 1'b0;
    tick();
    readout_idle = 1'b1;
    tick();
    check("ab_c5_use_lane", 16'(use_lane), 16'h7);
    tick();
    check("ab_c6_use_lane", 16'(use_lane), 16'h2);
    tick(); tick();
    strobe(1'b1, 4'h4, 1'b0, 4'h0);
    wait_done("ab_done1", 40);
    check("ab_done1_use_lane", 16'(use_lane), 16'h2);
    tick();
    check("ab_restart_busy", 16'(busy), 16'h1);
    check("ab_restart_pause", 16'(readout_pause), 16'h1);
    wait_done("ab_done2", 40);
    check("ab_done2_use_lane", 16'(use_lane), 16'h4);
    check("ab_done2_lane_src", 16'(lane_src), 16'h2);
    tick();

    // Reset during SETTLE
    strobe(1'b1, 4'h8, 1'b0, 4'h0);
    for (int c = 1; c < 6; c++) tick();
    check("rs_pre_use_lane", 16'(use_lane), 16'h8);
    check("rs_pre_pause", 16'(readout_pause), 16'h1);
    reset = 1'b1;
    #1;
    check("rs_use_lane", 16'(use_lane), 16'h0);
    check("rs_lane_src", 16'(lane_src), 16'h0);
    check("rs_pause", 16'(readout_pause), 16'h0);
    check("rs_busy", 16'(busy), 16'h0);
    tick(); tick();
    reset = 1'b0;
    saw_busy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (busy) saw_busy = 1'b1;
    end
    check("rs_no_seq", 16'(saw_busy), 16'h0);
    check("rs_post_use_lane", 16'(use_lane), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
